// File: rtl/stage2_sched_pkg.sv
// Shared definitions for the stage-2 front-end scheduler and the stage2_hash-level top.
package stage2_sched_pkg;

  localparam int unsigned HW_DEF       = 10;
  localparam int unsigned DW_DEF       = 64;
  localparam int unsigned PIPE_LAT_DEF = 3;
  localparam int unsigned INS_GAP_DEF  = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/stage2_rr_arb.sv
// Two-requester round-robin arbiter; grants are combinational, the priority pointer is registered.
module stage2_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a_c,
  output logic gnt_b_c
);

  logic prio_a;

  always_comb begin
    gnt_a_c = en & req_a & (~req_b | prio_a);
    gnt_b_c = en & req_b & (~req_a | ~prio_a);
  end

  // Pointer moves only on a real grant; after reset requester a wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_a <= 1'b1;
    end else if (gnt_a_c) begin
      prio_a <= 1'b0;
    end else if (gnt_b_c) begin
      prio_a <= 1'b1;
    end
  end

endmodule

// File: rtl/stage2_sched.sv
// Stage-2 front end: round-robin issue of insert/search ops with an insert hazard gap,
// tagged search results and a drain-then-clear table sequence.
module stage2_sched
  import stage2_sched_pkg::*;
#(
  parameter int unsigned HW       = HW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned INS_GAP  = INS_GAP_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ins_valid_i,
  output logic          ins_ready_o,
  input  logic [DW-1:0] ins_key_i,
  input  logic [DW-1:0] ins_lat_i,
  input  logic          srch_valid_i,
  output logic          srch_ready_o,
  input  logic [DW-1:0] srch_key_i,
  output logic          s2_insert_o,
  output logic [DW-1:0] s2_insert_data_o,
  output logic [DW-1:0] s2_insert_latency_o,
  output logic          s2_search_o,
  output logic [DW-1:0] s2_search_data_o,
  input  logic          s2_insert_end_i,
  input  logic          s2_search_end_i,
  input  logic [DW-1:0] s2_search_freq_i,
  input  logic [DW-1:0] s2_search_latency_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_key_o,
  output logic [DW-1:0] rsp_freq_o,
  output logic [DW-1:0] rsp_latency_o,
  input  logic          clear_i,
  output logic          clr_we_o,
  output logic [HW-1:0] clr_addr_o,
  output logic          clear_done_o,
  output logic          busy_o
);

  localparam int unsigned GW = $clog2(INS_GAP + 2);
  localparam int unsigned PW = $clog2(PIPE_LAT + 2);
  localparam logic [HW-1:0] ADDR_LAST = '1;

  sched_state_t         state;
  logic [GW-1:0]        gap_cnt;
  logic [PW-1:0]        pipe_cnt;
  logic [PW-1:0]        pipe_nxt;
  logic [2:0][DW-1:0]   key_dly;
  logic                 arb_en;
  logic                 ins_go;
  logic                 srch_go;
  logic                 inflight;

  // Issue is allowed only in RUN, outside the insert gap, and never in the clear-request cycle.
  assign arb_en = (state == ST_RUN) && (gap_cnt == '0) && !clear_i;

  stage2_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .req_a   (ins_valid_i),
    .req_b   (srch_valid_i),
    .gnt_a_c (ins_go),
    .gnt_b_c (srch_go)
  );

  assign ins_ready_o  = ins_go;
  assign srch_ready_o = srch_go;

  always_comb begin
    pipe_nxt = pipe_cnt;
    if (ins_go || srch_go) begin
      pipe_nxt = PW'(PIPE_LAT);
    end else if (pipe_cnt != '0) begin
      pipe_nxt = pipe_cnt - PW'(1);
    end
    inflight = (pipe_nxt != '0) | s2_insert_end_i | s2_search_end_i;
  end

  // Issue registers, insert gap, drain counter, search key delay line and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_insert_o         <= 1'b0;
      s2_insert_data_o    <= '0;
      s2_insert_latency_o <= '0;
      s2_search_o         <= 1'b0;
      s2_search_data_o    <= '0;
      gap_cnt             <= '0;
      pipe_cnt            <= '0;
      key_dly             <= '0;
      rsp_valid_o         <= 1'b0;
      rsp_key_o           <= '0;
      rsp_freq_o          <= '0;
      rsp_latency_o       <= '0;
    end else begin
      s2_insert_o <= ins_go;
      s2_search_o <= srch_go;
      if (ins_go) begin
        s2_insert_data_o    <= ins_key_i;
        s2_insert_latency_o <= ins_lat_i;
      end
      if (srch_go) begin
        s2_search_data_o <= srch_key_i;
      end
      if (ins_go) begin
        gap_cnt <= GW'(INS_GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      pipe_cnt    <= pipe_nxt;
      key_dly     <= {key_dly[1], key_dly[0], (srch_go ? srch_key_i : DW'(0))};
      rsp_valid_o <= s2_search_end_i;
      if (s2_search_end_i) begin
        rsp_key_o     <= key_dly[2];
        rsp_freq_o    <= s2_search_freq_i;
        rsp_latency_o <= s2_search_latency_i;
      end
    end
  end

  // Control FSM: RUN -> DRAIN -> CLEAR (one write per address) -> DONE -> RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      clr_we_o     <= 1'b0;
      clr_addr_o   <= '0;
      clear_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (clear_i) begin
            state  <= ST_DRAIN;
            busy_o <= 1'b1;
          end else begin
            busy_o <= inflight;
          end
        end
        ST_DRAIN: begin
          busy_o <= 1'b1;
          if (pipe_cnt == '0) begin
            state      <= ST_CLEAR;
            clr_we_o   <= 1'b1;
            clr_addr_o <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_addr_o == ADDR_LAST) begin
            state        <= ST_DONE;
            clr_we_o     <= 1'b0;
            clr_addr_o   <= '0;
            clear_done_o <= 1'b1;
            busy_o       <= inflight;
          end else begin
            clr_addr_o <= clr_addr_o + HW'(1);
            busy_o     <= 1'b1;
          end
        end
        ST_DONE: begin
          state        <= ST_RUN;
          clear_done_o <= 1'b0;
          busy_o       <= inflight;
        end
        default: begin
          state    <= ST_RUN;
          clr_we_o <= 1'b0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage2_sched.sv
// Directed bench for stage2_sched (HW=4) with a fixed-latency stage-2 model.
module tb_stage2_sched;

  localparam int unsigned HW = 4;
  localparam int unsigned DW = 64;

  logic          clk;
  logic          rst;
  logic          ins_valid, ins_ready;
  logic [DW-1:0] ins_key, ins_lat;
  logic          srch_valid, srch_ready;
  logic [DW-1:0] srch_key;
  logic          s2_insert, s2_search;
  logic [DW-1:0] s2_insert_data, s2_insert_latency, s2_search_data;
  logic          s2_insert_end, s2_search_end;
  logic [DW-1:0] s2_search_freq, s2_search_latency;
  logic          rsp_valid;
  logic [DW-1:0] rsp_key, rsp_freq, rsp_latency;
  logic          clear, clr_we, clear_done, busy;
  logic [HW-1:0] clr_addr;

  int n_checks;
  int n_fail;

  stage2_sched #(.HW(HW), .DW(DW), .INS_GAP(2), .PIPE_LAT(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ins_valid_i         (ins_valid),
    .ins_ready_o         (ins_ready),
    .ins_key_i           (ins_key),
    .ins_lat_i           (ins_lat),
    .srch_valid_i        (srch_valid),
    .srch_ready_o        (srch_ready),
    .srch_key_i          (srch_key),
    .s2_insert_o         (s2_insert),
    .s2_insert_data_o    (s2_insert_data),
    .s2_insert_latency_o (s2_insert_latency),
    .s2_search_o         (s2_search),
    .s2_search_data_o    (s2_search_data),
    .s2_insert_end_i     (s2_insert_end),
    .s2_search_end_i     (s2_search_end),
    .s2_search_freq_i    (s2_search_freq),
    .s2_search_latency_i (s2_search_latency),
    .rsp_valid_o         (rsp_valid),
    .rsp_key_o           (rsp_key),
    .rsp_freq_o          (rsp_freq),
    .rsp_latency_o       (rsp_latency),
    .clear_i             (clear),
    .clr_we_o            (clr_we),
    .clr_addr_o          (clr_addr),
    .clear_done_o        (clear_done),
    .busy_o              (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stage-2 model: end flags two cycles after the strobe; freq from a small key table, latency = 2*key.
  function automatic logic [DW-1:0] freq_of(input logic [DW-1:0] key);
    case (key)
      64'hA:   freq_of = 64'd7;
      64'hB:   freq_of = 64'd3;
      64'hC:   freq_of = 64'd0;
      default: freq_of = key + 64'd1;
    endcase
  endfunction

  logic          sp1, sp2, ip1, ip2;
  logic [DW-1:0] f1, f2, l1, l2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp1 <= 1'b0; sp2 <= 1'b0; ip1 <= 1'b0; ip2 <= 1'b0;
      f1 <= '0; f2 <= '0; l1 <= '0; l2 <= '0;
    end else begin
      sp1 <= s2_search;
      sp2 <= sp1;
      ip1 <= s2_insert;
      ip2 <= ip1;
      f1  <= freq_of(s2_search_data);
      f2  <= f1;
      l1  <= s2_search_data << 1;
      l2  <= l1;
    end
  end

  assign s2_search_end     = sp2;
  assign s2_insert_end     = ip2;
  assign s2_search_freq    = f2;
  assign s2_search_latency = l2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ins_valid = 1'b0; srch_valid = 1'b0; clear = 1'b0;
    ins_key = '0; ins_lat = '0; srch_key = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic [7:0] e_rdy, e_stb, e_irdy, e_srdy, e_istb, e_sstb;
  logic [DW-1:0] exp_freq [3];
  logic [DW-1:0] exp_lat  [3];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_freq = '{64'd7, 64'd3, 64'd0};
    exp_lat  = '{64'h14, 64'h16, 64'h18};
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ins_stb", s2_insert, 0);
    check("rst_srch_stb", s2_search, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_we", clr_we, 0);
    check("rst_done", clear_done, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", clr_addr, 0);
    rst = 1'b0;

    // single insert
    cyc(); ins_valid = 1'b1; ins_key = 64'h5; ins_lat = 64'd100; #1;
    check("t1_rdy", ins_ready, 1);
    cyc(); ins_valid = 1'b0; #1;
    check("t1_stb", s2_insert, 1);
    check("t1_key", s2_insert_data, 64'h5);
    check("t1_lat", s2_insert_latency, 64'd100);
    check("t1_srch", s2_search, 0);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      check("t1_stb_off", s2_insert, 0);
      check("t1_no_rsp", rsp_valid, 0);
    end

    // back-to-back inserts: issues every 3 cycles
    e_rdy = 8'b0100_1001;
    e_stb = 8'b1001_0010;
    for (int i = 0; i < 8; i++) begin
      cyc(); ins_valid = 1'b1; ins_key = 64'h20 + 64'(i); #1;
      check("t2_rdy", ins_ready, e_rdy[i]);
      check("t2_stb", s2_insert, e_stb[i]);
      if (i == 1) check("t2_key0", s2_insert_data, 64'h20);
      if (i == 4) check("t2_key1", s2_insert_data, 64'h23);
    end
    cyc(); idle_inputs();
    repeat (3) cyc();

    // both streams valid after reset: I,-,-,S,I,-,-,S
    do_reset();
    e_irdy = 8'b0001_0001;
    e_srdy = 8'b1000_1000;
    e_istb = 8'b0010_0010;
    e_sstb = 8'b0001_0000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      ins_valid = 1'b1; ins_key = 64'h30 + 64'(i);
      srch_valid = 1'b1; srch_key = 64'h40 + 64'(i);
      #1;
      check("t3_irdy", ins_ready, e_irdy[i]);
      check("t3_srdy", srch_ready, e_srdy[i]);
      check("t3_istb", s2_insert, e_istb[i]);
      check("t3_sstb", s2_search, e_sstb[i]);
      check("t3_excl", s2_insert & s2_search, 0);
    end
    cyc(); idle_inputs();
    repeat (8) cyc();

    // three consecutive searches, results at t+4..t+6
    for (int i = 0; i < 8; i++) begin
      cyc();
      srch_valid = (i < 3);
      srch_key = 64'hA + 64'(i);
      #1;
      if (i < 3) check("t4_srdy", srch_ready, 1);
      check("t4_sstb", s2_search, (i >= 1 && i <= 3));
      check("t4_rsp", rsp_valid, (i >= 4 && i <= 6));
      if (i >= 4 && i <= 6) begin
        check("t4_key", rsp_key, 64'hA + 64'(i - 4));
        check("t4_freq", rsp_freq, exp_freq[i-4]);
        check("t4_lat", rsp_latency, exp_lat[i-4]);
      end
    end
    cyc(); idle_inputs();
    repeat (4) cyc();

    // clear during mixed traffic: drain 3, 16 clear writes, done pulse, readies back
    for (int i = 0; i < 28; i++) begin
      cyc();
      ins_valid = 1'b1; ins_key = 64'h50 + 64'(i); ins_lat = 64'(i);
      srch_valid = 1'b1; srch_key = 64'h60 + 64'(i);
      clear = (i >= 4 && i <= 10);
      #1;
      check("t5_irdy", ins_ready, (i == 0 || i == 25));
      check("t5_srdy", srch_ready, (i == 3));
      check("t5_istb", s2_insert, (i == 1 || i == 26));
      check("t5_sstb", s2_search, (i == 4));
      check("t5_we", clr_we, (i >= 8 && i <= 23));
      check("t5_addr", clr_addr, (i >= 8 && i <= 23) ? 64'(i - 8) : 64'd0);
      check("t5_done", clear_done, (i == 24));
      check("t5_rsp", rsp_valid, (i == 7));
      if (i >= 5 && i <= 23) check("t5_busy", busy, 1);
      if (i == 1) check("t5_ikey", s2_insert_data, 64'h50);
      if (i == 7) check("t5_rkey", rsp_key, 64'h63);
    end
    cyc(); idle_inputs();
    repeat (5) cyc();

    // reset in the fifth cycle of CLEAR
    cyc(); clear = 1'b1;
    cyc(); clear = 1'b0;
    repeat (5) cyc();
    check("t6_pre_we", clr_we, 1);
    check("t6_pre_addr", clr_addr, 4);
    rst = 1'b1; #1;
    check("t6_we", clr_we, 0);
    check("t6_busy", busy, 0);
    check("t6_addr", clr_addr, 0);
    check("t6_istb", s2_insert, 0);
    check("t6_sstb", s2_search, 0);
    check("t6_done", clear_done, 0);
    cyc(); rst = 1'b0; ins_valid = 1'b1; ins_key = 64'h77; #1;
    check("t6_irdy", ins_ready, 1);
    cyc(); ins_valid = 1'b0; #1;
    check("t6_istb_post", s2_insert, 1);
    check("t6_we_post", clr_we, 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
